// File: rtl/adat_rx_pkg.sv
// -----------------------------------------------------------------------------
// adat_rx_pkg
// Shared types and constants for the ADAT receive lock/alignment controller.
//   lock_state_t : controller state encoding (SEARCH, VERIFY, LOCKED)
//   ADAT_NUM_CH  : channels carried per ADAT frame
//   ADAT_CH_W    : width of the parser channel index
//   ADAT_USER_W  : width of the per-frame user nibble
//   ADAT_EXP_W   : width of the expected-channel tracker (needs to hold NUM_CH)
// -----------------------------------------------------------------------------
package adat_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int ADAT_NUM_CH = 8;
    localparam int ADAT_CH_W   = 3;
    localparam int ADAT_USER_W = 4;
    localparam int ADAT_EXP_W  = ADAT_CH_W + 1;

endpackage

// File: rtl/adat_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// adat_rx_frame_checker
// Tracks the channel sequence of the frame in progress and grades it when the
// next sync arrives. A frame is good only if channels 0..7 arrived exactly once
// each, in order.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_clear        sync detected this cycle; restart tracking after this edge
//   i_data_valid   parser channel strobe
//   i_channel      parser channel index (valid with i_data_valid)
//   i_user         parser user bits, captured on the channel-0 strobe
//   o_frame_good   grade of the frame ending this cycle (meaningful with i_clear)
//   o_user         pending user nibble of the frame ending this cycle
//
// Both outputs include a strobe arriving in the same cycle, so a last channel
// coincident with sync still counts toward the frame being graded.
// -----------------------------------------------------------------------------
module adat_rx_frame_checker
    import adat_rx_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_data_valid,
    input  logic [ADAT_CH_W-1:0]   i_channel,
    input  logic [ADAT_USER_W-1:0] i_user,
    output logic                   o_frame_good,
    output logic [ADAT_USER_W-1:0] o_user
);

    localparam logic [ADAT_EXP_W-1:0] EXP_FULL = ADAT_EXP_W'(ADAT_NUM_CH);
    localparam logic [ADAT_EXP_W-1:0] EXP_ONE  = ADAT_EXP_W'(1);

    logic [ADAT_EXP_W-1:0]  r_exp_ch;
    logic                   r_seq_err;
    logic [ADAT_USER_W-1:0] r_user;

    logic [ADAT_EXP_W-1:0]  w_exp_nxt;
    logic                   w_seq_nxt;
    logic [ADAT_USER_W-1:0] w_user_nxt;

    always_comb begin
        w_exp_nxt  = r_exp_ch;
        w_seq_nxt  = r_seq_err;
        w_user_nxt = r_user;
        if (i_data_valid) begin
            // A strobe after all channels were seen is also out of sequence.
            if ((i_channel == r_exp_ch[ADAT_CH_W-1:0]) && (r_exp_ch < EXP_FULL)) begin
                w_exp_nxt = r_exp_ch + EXP_ONE;
            end else begin
                w_seq_nxt = 1'b1;
            end
            if (i_channel == '0) begin
                w_user_nxt = i_user;
            end
        end
    end

    assign o_frame_good = (w_exp_nxt == EXP_FULL) && !w_seq_nxt;
    assign o_user       = w_user_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp_ch  <= '0;
            r_seq_err <= 1'b0;
            r_user    <= '0;
        end else begin
            r_user <= w_user_nxt;
            if (i_clear) begin
                r_exp_ch  <= '0;
                r_seq_err <= 1'b0;
            end else begin
                r_exp_ch  <= w_exp_nxt;
                r_seq_err <= w_seq_nxt;
            end
        end
    end

endmodule

// File: rtl/adat_rx_lock_ctrl.sv
// -----------------------------------------------------------------------------
// adat_rx_lock_ctrl
// Lock/alignment controller for the ADAT receive chain. Grades each frame
// between sync detections, declares lock after LOCK_FRAMES consecutive good
// frames and drops it after UNLOCK_FRAMES consecutive bad or missing frames.
//
// Build option:
//   ADAT_RX_ERR_COUNT_EN  defined   -> saturating bad/missing frame counter
//                         undefined -> counter not built, o_err_count = 0
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_sync_det     one-cycle pulse, sync pattern detected (frame boundary)
//   i_data_valid   parser channel strobe
//   i_channel      parser channel index
//   i_user         parser user bits, sampled with channel 0
//   o_parser_sync  enable to the frame parser; 0 holds the parser
//   o_locked       high while LOCKED
//   o_frame_valid  one-cycle pulse per good frame while locked
//   o_frame_user   user nibble of the last good locked frame
//   o_err_count    saturating count of bad/missing frames
//
// state  | meaning
// SEARCH | parser held, waiting for any sync to establish alignment
// VERIFY | aligned, counting consecutive good frames toward lock
// LOCKED | locked, tolerating up to UNLOCK_FRAMES-1 consecutive bad frames
// -----------------------------------------------------------------------------
module adat_rx_lock_ctrl
    import adat_rx_pkg::*;
#(
    parameter int LOCK_FRAMES    = 4,
    parameter int UNLOCK_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_sync_det,
    input  logic                   i_data_valid,
    input  logic [ADAT_CH_W-1:0]   i_channel,
    input  logic [ADAT_USER_W-1:0] i_user,
    output logic                   o_parser_sync,
    output logic                   o_locked,
    output logic                   o_frame_valid,
    output logic [ADAT_USER_W-1:0] o_frame_user,
    output logic [15:0]            o_err_count
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_FRAMES);
    localparam logic [BW-1:0] UNLOCK_N = BW'(UNLOCK_FRAMES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    lock_state_t            r_state;
    logic [GW-1:0]          r_good_cnt;
    logic [BW-1:0]          r_bad_cnt;
    logic [TW-1:0]          r_tmo_cnt;
    logic                   r_parser_sync;
    logic                   r_locked;
    logic                   r_frame_valid;
    logic [ADAT_USER_W-1:0] r_frame_user;

    logic                   w_frame_good;
    logic [ADAT_USER_W-1:0] w_user;
    logic                   w_tmo;
    logic [GW-1:0]          w_good_nxt;
    logic [BW-1:0]          w_bad_nxt;

    adat_rx_frame_checker u_checker (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_sync_det),
        .i_data_valid (i_data_valid),
        .i_channel    (i_channel),
        .i_user       (i_user),
        .o_frame_good (w_frame_good),
        .o_user       (w_user)
    );

    // Missing-frame detector: fires on the TIMEOUT_CYCLES-th clock without a
    // sync. A sync in that same cycle wins and suppresses the event.
    assign w_tmo = !i_sync_det && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (i_sync_det || w_tmo) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign w_good_nxt = r_good_cnt + GW'(1);
    assign w_bad_nxt  = r_bad_cnt + BW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= SEARCH;
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_parser_sync <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_user  <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                SEARCH: begin
                    // First sync only aligns the parser; nothing is graded.
                    if (i_sync_det) begin
                        r_state       <= VERIFY;
                        r_good_cnt    <= '0;
                        r_parser_sync <= 1'b1;
                    end
                end
                VERIFY: begin
                    if (i_sync_det && w_frame_good) begin
                        r_good_cnt <= w_good_nxt;
                        if (w_good_nxt == LOCK_N) begin
                            r_state       <= LOCKED;
                            r_bad_cnt     <= '0;
                            r_locked      <= 1'b1;
                            r_frame_valid <= 1'b1;
                            r_frame_user  <= w_user;
                        end
                    end else if (i_sync_det || w_tmo) begin
                        r_state       <= SEARCH;
                        r_parser_sync <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (i_sync_det && w_frame_good) begin
                        r_bad_cnt     <= '0;
                        r_frame_valid <= 1'b1;
                        r_frame_user  <= w_user;
                    end else if (i_sync_det || w_tmo) begin
                        if (w_bad_nxt == UNLOCK_N) begin
                            r_state       <= SEARCH;
                            r_bad_cnt     <= '0;
                            r_locked      <= 1'b0;
                            r_parser_sync <= 1'b0;
                        end else begin
                            r_bad_cnt <= w_bad_nxt;
                        end
                    end
                end
                default: begin
                    r_state       <= SEARCH;
                    r_parser_sync <= 1'b0;
                    r_locked      <= 1'b0;
                end
            endcase
        end
    end

    assign o_parser_sync = r_parser_sync;
    assign o_locked      = r_locked;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_user  = r_frame_user;

`ifdef ADAT_RX_ERR_COUNT_EN
    logic        w_bad_event;
    logic [15:0] r_err_count;

    // Bad sync or missing frame while aligned; SEARCH ignores both.
    assign w_bad_event = (r_state != SEARCH) &&
                         ((i_sync_det && !w_frame_good) || w_tmo);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_count <= '0;
        end else if (w_bad_event && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign o_err_count = r_err_count;
`else
    assign o_err_count = '0;
`endif

endmodule
